// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks at most one of the execution queues each
// cycle (urgent class first, round-robin within each class) and registers the
// winner's tag/result as the cdb broadcast seen by rename and the queues.
module cdb_arbiter #(
  parameter int N_REQ  = 4,   // 0=int, 1=mult, 2=div, 3=mem
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,        // async, active-low
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          urgent,
  input  logic [N_REQ*TAG_W-1:0]    req_tag,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic                      flush,
  output logic [N_REQ-1:0]          gnt,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [1:0]                cdb_src
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Round-robin pointers, one per priority class.
  logic [PTR_W-1:0]  rr_urg_q,  rr_urg_d;
  logic [PTR_W-1:0]  rr_norm_q, rr_norm_d;

  // Registered broadcast.
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q,  cdb_data_d;
  logic [1:0]        cdb_src_q,   cdb_src_d;

  // Arbitration intermediates.
  logic [N_REQ-1:0]  urg_set;
  logic [N_REQ-1:0]  cand;
  logic              use_urg;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  winner;
  logic [PTR_W-1:0]  ptr_next;
  logic              found;
  logic              grant;
  logic [PTR_W:0]    scan_sum;
  logic [PTR_W-1:0]  scan_idx;
  logic [PTR_W:0]    inc_sum;

  // Class selection: any qualified urgent request switches arbitration to
  // the urgent set and its own pointer; urgent without req is ignored.
  always_comb begin
    urg_set = req & urgent;
    use_urg = |urg_set;
    cand    = use_urg ? urg_set : req;
    ptr     = use_urg ? rr_urg_q : rr_norm_q;
  end

  // Round-robin scan: first candidate at or above the pointer, wrapping.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(N_REQ)) begin
        scan_sum = scan_sum - (PTR_W+1)'(N_REQ);
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!found && cand[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  // Grant is suppressed during reset and flush; flush also beats urgent.
  always_comb begin
    grant = found & rst & ~flush;
    gnt   = '0;
    if (grant) begin
      gnt[winner] = 1'b1;
    end
  end

  // Pointer successor of the winner, modulo N_REQ.
  always_comb begin
    inc_sum = {1'b0, winner} + (PTR_W+1)'(1);
    if (inc_sum >= (PTR_W+1)'(N_REQ)) begin
      inc_sum = '0;
    end
    ptr_next = inc_sum[PTR_W-1:0];
  end

  // Next state: advance only the class pointer that produced the grant and
  // capture the winner's payload; without a grant the payload holds.
  always_comb begin
    rr_urg_d    = rr_urg_q;
    rr_norm_d   = rr_norm_q;
    cdb_valid_d = grant;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (grant) begin
      if (use_urg) begin
        rr_urg_d = ptr_next;
      end else begin
        rr_norm_d = ptr_next;
      end
      cdb_tag_d  = req_tag[int'(winner)*TAG_W +: TAG_W];
      cdb_data_d = req_data[int'(winner)*DATA_W +: DATA_W];
      cdb_src_d  = 2'(winner);
    end
  end

  // State registers with asynchronous clear of pointers and broadcast.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_urg_q    <= '0;
      rr_norm_q   <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_urg_q    <= rr_urg_d;
      rr_norm_q   <= rr_norm_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural arbitration model.
module tb_cdb_arbiter;

  localparam int N = 4;
  localparam int TW = 6;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    urgent;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic            flush;
  logic [N-1:0]    gnt;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [1:0]      cdb_src;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int          m_ptr_urg;
  int          m_ptr_norm;
  logic        m_valid;
  logic [5:0]  m_tag;
  logic [31:0] m_data;
  logic [1:0]  m_src;

  cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .urgent   (urgent),
    .req_tag  (req_tag),
    .req_data (req_data),
    .flush    (flush),
    .gnt      (gnt),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_data (cdb_data),
    .cdb_src  (cdb_src)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Winning unit under the arbitration rules, or -1 if nobody is granted.
  function automatic int model_winner();
    logic [N-1:0] pool;
    int p;
    if (rst !== 1'b1 || flush === 1'b1) return -1;
    if ((req & urgent) != 0) begin
      pool = req & urgent;
      p    = m_ptr_urg;
    end else begin
      pool = req;
      p    = m_ptr_norm;
    end
    for (int k = 0; k < N; k++) begin
      if (pool[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_gnt();
    int w;
    w = model_winner();
    return (w < 0) ? 4'b0000 : 4'(1 << w);
  endfunction

  task automatic model_init();
    m_ptr_urg  = 0;
    m_ptr_norm = 0;
    m_valid    = 1'b0;
    m_tag      = '0;
    m_data     = '0;
    m_src      = '0;
  endtask

  // Applies one clock edge's effect to the model (inputs are stable here).
  task automatic model_edge();
    int w;
    bit urg;
    w   = model_winner();
    urg = ((req & urgent) != 0);
    if (w >= 0) begin
      m_valid = 1'b1;
      m_tag   = req_tag[w*TW +: TW];
      m_data  = req_data[w*DW +: DW];
      m_src   = 2'(w);
      if (urg) m_ptr_urg = (w + 1) % N;
      else     m_ptr_norm = (w + 1) % N;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  // Advance to just after the next rising edge, updating the model.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_unit(input int i, input logic [5:0] t, input logic [31:0] d);
    req_tag[i*TW +: TW]  = t;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    req    = '0;
    urgent = '0;
    flush  = 1'b0;
    repeat (2) @(posedge clk);
    model_init();
    @(negedge clk);
    #2 rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    req    = 4'b1111;
    urgent = '0;
    flush  = 1'b0;
    for (int i = 0; i < N; i++) set_unit(i, 6'(8 + i), 32'h1000 + i);
    model_init();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (gnt !== 4'b0000) begin
      bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt);
    end
    total++;
    if ({cdb_valid, cdb_src, cdb_tag, cdb_data} !== '0) begin
      bad++; $display("FAIL reset_cdb got valid=%b src=%0d tag=%h data=%h exp all zero",
                      cdb_valid, cdb_src, cdb_tag, cdb_data);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (gnt !== 4'b0001) begin
      bad++; $display("FAIL reset_first_gnt got=%b exp=0001", gnt);
    end
    step();
    total++;
    if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_tag !== 6'd8) begin
      bad++; $display("FAIL reset_first_cdb got valid=%b src=%0d tag=%h exp valid=1 src=0 tag=08",
                      cdb_valid, cdb_src, cdb_tag);
    end
  endtask

  task automatic test_round_robin();
    int w;
    int cnt [N];
    logic [3:0] eg;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    req    = 4'b1111;
    urgent = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      eg = model_gnt();
      w  = model_winner();
      total++;
      if (gnt !== eg) begin
        bad++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", c, gnt, eg);
      end
      if (w >= 0) cnt[w]++;
      step();
      total++;
      if (cdb_valid !== 1'b1 || cdb_tag !== m_tag || cdb_src !== m_src) begin
        bad++; $display("FAIL rr_cdb cyc=%0d got valid=%b tag=%h src=%0d exp valid=1 tag=%h src=%0d",
                        c, cdb_valid, cdb_tag, cdb_src, m_tag, m_src);
      end
      if (w >= 0) set_unit(w, 6'($urandom), $urandom);
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (cnt[i] != 2) begin
        bad++; $display("FAIL rr_fairness unit=%0d got=%0d grants exp=2", i, cnt[i]);
      end
    end
  endtask

  task automatic test_urgent();
    do_reset();
    req = 4'b0001;
    step();                          // unit 0 granted, normal pointer -> 1
    req    = 4'b1111;
    urgent = 4'b1000;
    @(negedge clk);
    total++;
    if (gnt !== 4'b1000) begin
      bad++; $display("FAIL urgent_preempt got=%b exp=1000", gnt);
    end
    step();
    urgent = 4'b0000;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0010) begin
      bad++; $display("FAIL urgent_norm_ptr_held got=%b exp=0010", gnt);
    end
    step();
    // urgent on an idle unit must not change the normal pick (pointer now 2)
    req    = 4'b1011;
    urgent = 4'b0100;
    @(negedge clk);
    total++;
    if (gnt !== 4'b1000) begin
      bad++; $display("FAIL urgent_without_req got=%b exp=1000", gnt);
    end
    step();
    urgent = '0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    set_unit(2, 6'h2A, 32'hDEADBEEF);
    @(negedge clk);
    total++;
    if (gnt !== 4'b0100) begin
      bad++; $display("FAIL single_gnt got=%b exp=0100", gnt);
    end
    step();
    total++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 6'h2A || cdb_data !== 32'hDEADBEEF || cdb_src !== 2'd2) begin
      bad++; $display("FAIL single_cdb got valid=%b tag=%h data=%h src=%0d exp 1 2a deadbeef 2",
                      cdb_valid, cdb_tag, cdb_data, cdb_src);
    end
    req = 4'b0000;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0000) begin
      bad++; $display("FAIL idle_gnt got=%b exp=0000", gnt);
    end
    step();
    total++;
    if (cdb_valid !== 1'b0 || cdb_tag !== 6'h2A || cdb_src !== 2'd2) begin
      bad++; $display("FAIL idle_hold got valid=%b tag=%h src=%0d exp valid=0 tag=2a src=2",
                      cdb_valid, cdb_tag, cdb_src);
    end
  endtask

  task automatic test_flush();
    do_reset();
    req = 4'b0011;
    set_unit(0, 6'h11, 32'hA0);
    set_unit(1, 6'h22, 32'hA1);
    @(negedge clk);
    total++;
    if (gnt !== 4'b0001) begin
      bad++; $display("FAIL flush_pre_gnt got=%b exp=0001", gnt);
    end
    step();                          // valid high, normal pointer -> 1
    set_unit(0, 6'h13, 32'hA2);
    flush  = 1'b1;
    urgent = 4'b0001;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0000) begin
      bad++; $display("FAIL flush_gnt got=%b exp=0000", gnt);
    end
    step();
    total++;
    if (cdb_valid !== 1'b0) begin
      bad++; $display("FAIL flush_kill got valid=%b exp=0", cdb_valid);
    end
    flush  = 1'b0;
    urgent = '0;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0010) begin
      bad++; $display("FAIL flush_after_gnt got=%b exp=0010", gnt);
    end
    step();
    total++;
    if (cdb_valid !== 1'b1 || cdb_src !== 2'd1 || cdb_tag !== 6'h22) begin
      bad++; $display("FAIL flush_after_cdb got valid=%b src=%0d tag=%h exp 1 1 22",
                      cdb_valid, cdb_src, cdb_tag);
    end
  endtask

  task automatic test_async_reset();
    req    = 4'b1111;
    urgent = '0;
    flush  = 1'b0;
    repeat (3) step();
    total++;
    if (cdb_valid !== 1'b1) begin
      bad++; $display("FAIL async_pre_valid got=%b exp=1", cdb_valid);
    end
    #2 rst = 1'b0;                   // mid-cycle, between edges
    #1;
    total++;
    if (cdb_valid !== 1'b0 || cdb_tag !== 6'h00 || gnt !== 4'b0000) begin
      bad++; $display("FAIL async_drop got valid=%b tag=%h gnt=%b exp 0 00 0000",
                      cdb_valid, cdb_tag, gnt);
    end
    model_init();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (gnt !== 4'b0001) begin
      bad++; $display("FAIL async_restart_gnt got=%b exp=0001", gnt);
    end
    step();
    total++;
    if (cdb_valid !== 1'b1 || cdb_src !== 2'd0) begin
      bad++; $display("FAIL async_restart_cdb got valid=%b src=%0d exp 1 0", cdb_valid, cdb_src);
    end
    req = '0;
    step();
  endtask

  task automatic test_random();
    int w;
    int age [N];
    logic [3:0] eg;
    // Phase 1: full random traffic with urgent and flush.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      eg = model_gnt();
      w  = model_winner();
      total++;
      if (gnt !== eg) begin
        bad++; $display("FAIL rand_gnt cyc=%0d req=%b urg=%b fl=%b got=%b exp=%b",
                        c, req, urgent, flush, gnt, eg);
      end
      step();
      total++;
      if ({cdb_valid, cdb_src, cdb_tag, cdb_data} !== {m_valid, m_src, m_tag, m_data}) begin
        bad++; $display("FAIL rand_cdb cyc=%0d got %b/%0d/%h/%h exp %b/%0d/%h/%h", c,
                        cdb_valid, cdb_src, cdb_tag, cdb_data, m_valid, m_src, m_tag, m_data);
      end
      if (w >= 0) begin
        if ($urandom_range(1, 0) == 1) set_unit(w, 6'($urandom), $urandom);
        else req[w] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(2, 0) == 0) begin
          req[i] = 1'b1;
          set_unit(i, 6'($urandom), $urandom);
        end
      end
      urgent = 4'($urandom);
      flush  = ($urandom_range(15, 0) == 0);
    end
    // Phase 2: normal traffic only; every request must win within N cycles.
    urgent = '0;
    flush  = 1'b0;
    for (int i = 0; i < N; i++) age[i] = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      w = model_winner();
      for (int i = 0; i < N; i++) if (req[i]) age[i]++;
      total++;
      if (gnt !== model_gnt()) begin
        bad++; $display("FAIL starve_gnt cyc=%0d got=%b exp=%b", c, gnt, model_gnt());
      end
      if (w >= 0) begin
        total++;
        if (age[w] > N) begin
          bad++; $display("FAIL starve_bound unit=%0d got wait=%0d exp<=%0d", w, age[w], N);
        end
        age[w] = 0;
      end
      step();
      if (w >= 0) begin
        if ($urandom_range(1, 0) == 1) set_unit(w, 6'($urandom), $urandom);
        else req[w] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(1, 0) == 0) begin
          req[i] = 1'b1;
          age[i] = 0;
          set_unit(i, 6'($urandom), $urandom);
        end
      end
    end
    req = '0;
  endtask

  initial begin
    req_tag  = '0;
    req_data = '0;
    test_reset();
    test_round_robin();
    test_urgent();
    test_single();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
